// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: code values,
// the active-high gfedcba pattern table and segment bit positions.
package seven_seg_pkg;

   localparam logic [4:0] CODE_BLANK = 5'd16;
   localparam logic [4:0] CODE_DASH  = 5'd17;

   localparam int unsigned SEG_DP = 7;

   localparam logic [6:0] PAT_BLANK = 7'h00;
   localparam logic [6:0] PAT_DASH  = 7'h40;

   // Entry 15 (F) first, entry 0 last; patterns are gfedcba, active-high.
   localparam logic [15:0][6:0] HEX_PAT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic is_zero_eq(input logic [4:0] code);
      return (code == 5'd0) || (code == CODE_BLANK);
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 5-bit display code to active-high gfedcba pattern.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [4:0] code_i,
   output logic [6:0] pat_o
);

   always_comb begin
      pat_o = PAT_BLANK;
      if (code_i < 5'd16) begin
         pat_o = HEX_PAT[code_i[3:0]];
      end else if (code_i == CODE_DASH) begin
         pat_o = PAT_DASH;
      end
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment controller with tear-free frame loading,
// leading-zero suppression, per-digit blink and anti-ghost blanking.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter int unsigned BLINK_FRAMES   = 64,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [5*NUM_DIGITS-1:0]   load_codes,
   input  logic [NUM_DIGITS-1:0]     load_dp,
   input  logic [NUM_DIGITS-1:0]     load_blink,
   input  logic                      load_lz,
   output logic [7:0]                seg,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_tick
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [7:0]            SEG_XOR = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_XOR  = {NUM_DIGITS{AN_ACTIVE_LOW}};

   typedef struct packed {
      logic [5*NUM_DIGITS-1:0] codes;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blink;
      logic                    lz;
   } frame_t;

   localparam frame_t FRAME_RST = '{codes: {NUM_DIGITS{CODE_BLANK}}, dp: '0, blink: '0, lz: 1'b0};

   logic [CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [BLK_W-1:0]      blk_cnt_q;
   logic                  phase_q;
   logic                  tick_q;
   logic                  pend_q;
   frame_t                pend_buf_q;
   frame_t                act_q;
   logic [7:0]            seg_q;
   logic [NUM_DIGITS-1:0] an_q;

   logic                  slot_end;
   logic                  frame_end;
   frame_t                show;
   logic [4:0]            cur_code;
   logic                  cur_dp;
   logic                  cur_blink;
   logic                  lead;
   logic                  suppress;
   logic [4:0]            dec_code;
   logic [6:0]            pat;
   logic [7:0]            seg_d;
   logic [NUM_DIGITS-1:0] an_d;

   assign slot_end  = (cnt_q == CNT_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);

   // The pending frame is swapped in at the end of the tick cycle; during that
   // cycle it is already the one rendered, so digit 0 never shows a stale frame.
   assign show = (tick_q && pend_q) ? pend_buf_q : act_q;

   always_comb begin
      cur_code  = CODE_BLANK;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == idx_q) begin
            cur_code  = show.codes[5*i +: 5];
            cur_dp    = show.dp[i];
            cur_blink = show.blink[i];
         end
      end
   end

   // Walk from the leftmost digit: a digit is suppressed while every digit
   // from it up to the top is zero-equivalent; digit 0 is always shown.
   always_comb begin
      lead     = 1'b1;
      suppress = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (lead && !is_zero_eq(show.codes[5*(NUM_DIGITS-1-i) +: 5])) begin
            lead = 1'b0;
         end
         if (IDX_W'(NUM_DIGITS - 1 - i) == idx_q) begin
            suppress = lead && (i != NUM_DIGITS - 1);
         end
      end
   end

   assign dec_code = (suppress && show.lz) ? CODE_BLANK : cur_code;

   seven_seg_decode u_decode (
      .code_i (dec_code),
      .pat_o  (pat)
   );

   always_comb begin
      seg_d = '0;
      an_d  = '0;
      if (cnt_q >= CNT_W'(BLANK_CYCLES)) begin
         an_d = NUM_DIGITS'(1) << idx_q;
         if (!(phase_q && cur_blink)) begin
            seg_d = {cur_dp, pat};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         blk_cnt_q  <= '0;
         phase_q    <= 1'b0;
         tick_q     <= 1'b0;
         pend_q     <= 1'b0;
         pend_buf_q <= FRAME_RST;
         act_q      <= FRAME_RST;
         seg_q      <= SEG_XOR;
         an_q       <= AN_XOR;
      end else begin
         tick_q <= frame_end;
         cnt_q  <= slot_end ? '0 : cnt_q + 1'b1;
         if (slot_end) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end
         if (frame_end) begin
            if (blk_cnt_q == BLK_LAST) begin
               blk_cnt_q <= '0;
               phase_q   <= ~phase_q;
            end else begin
               blk_cnt_q <= blk_cnt_q + 1'b1;
            end
         end
         if (tick_q && pend_q) begin
            act_q  <= pend_buf_q;
            pend_q <= 1'b0;
         end
         if (load_valid && !pend_q) begin
            pend_buf_q <= '{codes: load_codes, dp: load_dp, blink: load_blink, lz: load_lz};
            pend_q     <= 1'b1;
         end
         seg_q <= seg_d ^ SEG_XOR;
         an_q  <= an_d ^ AN_XOR;
      end
   end

   assign load_ready = !pend_q;
   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: scan timing, handshake, zero suppression,
// blink and reset, with hand-computed active-low segment values.
module tb_seven_seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [19:0] load_codes;
   logic [3:0]  load_dp;
   logic [3:0]  load_blink;
   logic        load_lz;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned ticks  = 0;

   seven_seg_scan #(
      .NUM_DIGITS     (4),
      .REFRESH_DIV    (4),
      .BLANK_CYCLES   (1),
      .BLINK_FRAMES   (2),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_codes (load_codes),
      .load_dp    (load_dp),
      .load_blink (load_blink),
      .load_lz    (load_lz),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   always @(posedge frame_tick) ticks++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Waits for frame_tick (at a negedge), then samples the blank slot and the
   // middle of every digit slot; returns {d3,d2,d1,d0} segment bytes.
   task automatic grab_frame(input logic rdy_at_tick, output logic [31:0] segs);
      int unsigned n = 0;
      segs = '1;
      while (frame_tick !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("tick_seen", {31'b0, frame_tick}, 32'd1);
      chk("rdy_at_tick", {31'b0, load_ready}, {31'b0, rdy_at_tick});
      @(negedge clk);
      chk("rdy_after_tick", {31'b0, load_ready}, 32'd1);
      chk("an_blank", {28'b0, an}, 32'hF);
      chk("seg_blank", {24'b0, seg}, 32'hFF);
      for (int d = 0; d < 4; d++) begin
         logic [3:0] ea;
         ea = ~(4'b0001 << d);
         repeat ((d == 0) ? 2 : 4) @(negedge clk);
         chk($sformatf("an_d%0d", d), {28'b0, an}, {28'b0, ea});
         segs[8*d +: 8] = seg;
      end
   endtask

   task automatic chk_frame(input string tag, input logic [31:0] segs, input logic [31:0] exp);
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("%s_d%0d", tag, d), {24'b0, segs[8*d +: 8]}, {24'b0, exp[8*d +: 8]});
      end
   endtask

   task automatic send(input logic [19:0] codes, input logic [3:0] dp,
                       input logic [3:0] blink, input logic lz);
      int unsigned n = 0;
      logic sampled = 1'b0;
      repeat (5) @(negedge clk);
      load_codes = codes;
      load_dp    = dp;
      load_blink = blink;
      load_lz    = lz;
      load_valid = 1'b1;
      while (!sampled && n < 200) begin
         sampled = load_ready;
         @(negedge clk);
         n++;
      end
      chk("load_accept", {31'b0, sampled}, 32'd1);
      load_valid = 1'b0;
      chk("rdy_low_pending", {31'b0, load_ready}, 32'd0);
   endtask

   initial begin
      logic [31:0] s;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_codes = '0;
      load_dp    = '0;
      load_blink = '0;
      load_lz    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_seg", {24'b0, seg}, 32'hFF);
      chk("rst_an", {28'b0, an}, 32'hF);
      chk("rst_tick", {31'b0, frame_tick}, 32'd0);
      chk("rst_ready", {31'b0, load_ready}, 32'd1);
      rst = 1'b0;

      // Idle display is fully blank, frame_tick every 16 cycles
      grab_frame(1'b1, s);
      chk_frame("idle0", s, 32'hFFFF_FFFF);
      grab_frame(1'b1, s);
      chk_frame("idle1", s, 32'hFFFF_FFFF);
      chk("tick_not_early", {31'b0, frame_tick}, 32'd0);
      @(negedge clk);
      chk("tick_period", {31'b0, frame_tick}, 32'd1);

      // {1,2,8,0}, lz off
      send({5'd1, 5'd2, 5'd8, 5'd0}, 4'b0000, 4'b0000, 1'b0);
      grab_frame(1'b0, s);
      chk_frame("f1280", s, 32'hF9A4_80C0);

      // zeros shown when lz is off
      send({5'd0, 5'd0, 5'd0, 5'd7}, 4'b0000, 4'b0000, 1'b0);
      grab_frame(1'b0, s);
      chk_frame("nolz", s, 32'hC0C0_C0F8);

      // {0,0,5,0} lz on, dp on digit 0
      send({5'd0, 5'd0, 5'd5, 5'd0}, 4'b0001, 4'b0000, 1'b1);
      grab_frame(1'b0, s);
      chk_frame("lz0050", s, 32'hFFFF_9240);

      // BLANK counts as zero; dp on a suppressed digit still lit; digit 0 kept
      send({5'd16, 5'd0, 5'd0, 5'd0}, 4'b1000, 4'b0000, 1'b1);
      grab_frame(1'b0, s);
      chk_frame("lzdp", s, 32'h7FFF_FFC0);

      // Second frame held while first is pending
      send({5'd9, 5'd7, 5'd6, 5'd4}, 4'b0000, 4'b0000, 1'b0);
      load_codes = {5'd15, 5'd14, 5'd13, 5'd12};
      load_dp    = 4'b0000;
      load_blink = 4'b0000;
      load_lz    = 1'b0;
      load_valid = 1'b1;
      grab_frame(1'b0, s);
      chk_frame("held_a", s, 32'h90F8_8299);
      chk("held_b_captured", {31'b0, load_ready}, 32'd0);
      load_valid = 1'b0;
      grab_frame(1'b0, s);
      chk_frame("held_b", s, 32'h8E86_A1C6);

      // Blink on digit 1 (dash); phase flips every 2 frames
      send({5'd1, 5'd2, 5'd17, 5'd3}, 4'b0000, 4'b0010, 1'b0);
      for (int f = 0; f < 5; f++) begin
         logic [31:0] e;
         grab_frame((f == 0) ? 1'b0 : 1'b1, s);
         e = (((ticks >> 1) & 1) != 0) ? 32'hF9A4_FFB0 : 32'hF9A4_BFB0;
         chk_frame($sformatf("blink%0d", f), s, e);
      end

      // Reset mid-slot with a frame pending
      send({5'd8, 5'd8, 5'd8, 5'd8}, 4'b1111, 4'b0000, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_an", {28'b0, an}, 32'hF);
      chk("mid_rst_seg", {24'b0, seg}, 32'hFF);
      chk("mid_rst_ready", {31'b0, load_ready}, 32'd1);
      rst = 1'b0;
      grab_frame(1'b1, s);
      chk_frame("post_rst", s, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
